// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default baud divider.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int CLK_DIV_DEFAULT = 868;   // 100 MHz / 115200

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; head word is presented on dout while non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot the simultaneous push lands in, so full+pop still accepts.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    assign dout = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: synchronizes the line, decodes frames mid-bit and queues bytes in a FIFO.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx_i,
    output logic [7:0]                        byte_data_o,
    output logic                              byte_valid_o,
    input  logic                              byte_ready_i,
    output logic                              frame_err_o,
    output logic                              overflow_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o
);

    localparam int          IW        = $clog2(UART_DATA_BITS);
    localparam logic [15:0] HALF_LOAD = 16'(CLK_DIV/2 - 1);
    localparam logic [15:0] BIT_LOAD  = 16'(CLK_DIV - 1);

    logic                      rx_meta, rx_s;
    rx_state_e                 state, state_nx;
    logic [15:0]               bit_cnt, bit_cnt_nx;
    logic [IW-1:0]             bit_idx, bit_idx_nx;
    logic [UART_DATA_BITS-1:0] shreg, shreg_nx;
    logic                      push_req, frame_err_nx;
    logic                      fifo_empty, fifo_full, pop, push;

    // Idle-high reset value means a line already low at release reads as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            bit_idx     <= bit_idx_nx;
            shreg       <= shreg_nx;
            frame_err_o <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        push_req     = 1'b0;
        frame_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    bit_cnt_nx = HALF_LOAD;
                    state_nx   = START;
                end
            end
            START: begin
                if (bit_cnt == '0) begin
                    if (rx_s) begin
                        state_nx = IDLE;
                    end else begin
                        bit_cnt_nx = BIT_LOAD;
                        bit_idx_nx = '0;
                        state_nx   = DATA;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    shreg_nx   = {rx_s, shreg[UART_DATA_BITS-1:1]};
                    bit_cnt_nx = BIT_LOAD;
                    bit_idx_nx = bit_idx + IW'(1);
                    if (bit_idx == IW'(UART_DATA_BITS-1)) state_nx = STOP;
                end else begin
                    bit_cnt_nx = bit_cnt - 16'd1;
                end
            end
            STOP: begin
                if (bit_cnt == '0) begin
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = BRK;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt - 16'd1;
                end
            end
            BRK: begin
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign pop  = byte_valid_o & byte_ready_i;
    assign push = push_req & (~fifo_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              overflow_o <= 1'b0;
        else if (push_req & fifo_full & ~pop)    overflow_o <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (shreg),
        .dout  (byte_data_o),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count_o)
    );

    assign byte_valid_o = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Bench for uart_rx_capture: directed scenarios plus random frames against a queue-based model.
module tb_uart_rx_capture;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_i = 1'b1;
    logic          byte_ready_i = 1'b0;
    logic [7:0]    byte_data_o;
    logic          byte_valid_o, frame_err_o, overflow_o;
    logic [CW-1:0] fifo_count_o;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] got_q[$];
    int         fe_cnt = 0;
    int         vld_cycles = 0;
    bit         rnd_done;

    always #5 clk = ~clk;

    uart_rx_capture #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx_i),
        .byte_data_o  (byte_data_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .frame_err_o  (frame_err_o),
        .overflow_o   (overflow_o),
        .fifo_count_o (fifo_count_o)
    );

    // Observe consumed bytes and pulses half a cycle away from the active edge.
    always @(negedge clk) begin
        if (rst_n && byte_valid_o && byte_ready_i) got_q.push_back(byte_data_o);
        if (frame_err_o) fe_cnt++;
        if (byte_valid_o) vld_cycles++;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // pop_c >= 0 pulses byte_ready_i high for one cycle inside the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_c);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rx_i = stop;
        for (int c = 0; c < CLK_DIV; c++) begin
            @(posedge clk);
            #1;
            if (pop_c >= 0) byte_ready_i = (c == pop_c);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_i  = 1'b1;
        byte_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({byte_valid_o, byte_data_o, frame_err_o, overflow_o, fifo_count_o} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: v=%b d=%h fe=%b ov=%b cnt=%0d want all 0",
                     byte_valid_o, byte_data_o, frame_err_o, overflow_o, fifo_count_o);
        end
        rst_n = 1'b1;
        idle(4);
        n_cmp++;
        if ({byte_valid_o, byte_data_o, frame_err_o, overflow_o, fifo_count_o} !== '0) begin
            n_err++;
            $display("FAIL reset_release: v=%b d=%h fe=%b ov=%b cnt=%0d want all 0",
                     byte_valid_o, byte_data_o, frame_err_o, overflow_o, fifo_count_o);
        end
    endtask

    task automatic test_single();
        int base, v0, fe0;
        byte_ready_i = 1'b1;
        base = got_q.size(); v0 = vld_cycles; fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, -1);
        idle(4);
        n_cmp++;
        if (got_q.size() - base != 1) begin
            n_err++; $display("FAIL single_n: got %0d bytes want 1", got_q.size() - base);
        end else begin
            n_cmp++;
            if (got_q[base] !== 8'hA5) begin
                n_err++; $display("FAIL single_data: got %h want a5", got_q[base]);
            end
        end
        n_cmp++;
        if (vld_cycles - v0 != 1) begin
            n_err++; $display("FAIL single_valid_cycles: got %0d want 1", vld_cycles - v0);
        end
        n_cmp++;
        if (fe_cnt != fe0 || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL single_flags: fe=%0d ov=%b want 0 0", fe_cnt - fe0, overflow_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[3];
        int base;
        exp = '{8'h00, 8'hFF, 8'h55};
        byte_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, -1);
        idle(4);
        n_cmp++;
        if (fifo_count_o !== CW'(3)) begin
            n_err++; $display("FAIL b2b_count: got %0d want 3", fifo_count_o);
        end
        base = got_q.size();
        byte_ready_i = 1'b1;
        idle(6);
        byte_ready_i = 1'b0;
        n_cmp++;
        if (got_q.size() - base != 3) begin
            n_err++; $display("FAIL b2b_drain_n: got %0d want 3", got_q.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got_q[base+i] !== exp[i]) begin
                    n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        int base, fe0;
        byte_ready_i = 1'b1;
        base = got_q.size(); fe0 = fe_cnt;
        rx_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle(2 * CLK_DIV);
        n_cmp++;
        if (got_q.size() != base || fifo_count_o !== '0 || fe_cnt != fe0) begin
            n_err++; $display("FAIL glitch_nobyte: bytes=%0d cnt=%0d fe=%0d want 0 0 0",
                              got_q.size() - base, fifo_count_o, fe_cnt - fe0);
        end
        send_frame(8'h3C, 1'b1, -1);
        idle(4);
        n_cmp++;
        if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h3C) begin
            n_err++; $display("FAIL glitch_next: n=%0d last=%h want 1 3c",
                              got_q.size() - base, got_q[got_q.size()-1]);
        end
    endtask

    task automatic test_frame_err();
        int base, fe0;
        byte_ready_i = 1'b1;
        base = got_q.size(); fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, -1);
        repeat (2 * CLK_DIV) @(posedge clk);   // break: line stays low
        #1;
        idle(CLK_DIV);
        n_cmp++;
        if (fe_cnt - fe0 != 1) begin
            n_err++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0);
        end
        n_cmp++;
        if (got_q.size() != base || fifo_count_o !== '0) begin
            n_err++; $display("FAIL ferr_nobyte: bytes=%0d cnt=%0d want 0 0", got_q.size() - base, fifo_count_o);
        end
        send_frame(8'h7E, 1'b1, -1);
        idle(4);
        n_cmp++;
        if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h7E || fe_cnt - fe0 != 1) begin
            n_err++; $display("FAIL ferr_next: n=%0d last=%h fe=%0d want 1 7e 1",
                              got_q.size() - base, got_q[got_q.size()-1], fe_cnt - fe0);
        end
    endtask

    task automatic test_overflow();
        int base;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, -1);
            idle(2);
        end
        n_cmp++;
        if (fifo_count_o !== CW'(4) || overflow_o !== 1'b1) begin
            n_err++; $display("FAIL ovf_state: cnt=%0d ov=%b want 4 1", fifo_count_o, overflow_o);
        end
        base = got_q.size();
        byte_ready_i = 1'b1;
        idle(8);
        byte_ready_i = 1'b0;
        n_cmp++;
        if (got_q.size() - base != 4) begin
            n_err++; $display("FAIL ovf_drain_n: got %0d want 4", got_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_q[base+i] !== 8'(i + 1)) begin
                    n_err++; $display("FAIL ovf_data[%0d]: got %h want %h", i, got_q[base+i], 8'(i + 1));
                end
            end
        end
        n_cmp++;
        if (overflow_o !== 1'b1 || fifo_count_o !== '0) begin
            n_err++; $display("FAIL ovf_sticky: ov=%b cnt=%0d want 1 0", overflow_o, fifo_count_o);
        end
    endtask

    // Pop lands on the same edge as the 5th byte's stop-bit sample.
    task automatic test_overflow_pop();
        int base;
        do_reset();
        n_cmp++;
        if (overflow_o !== 1'b0) begin
            n_err++; $display("FAIL ovfpop_cleared: ov=%b want 0", overflow_o);
        end
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, -1);
        base = got_q.size();
        send_frame(8'h05, 1'b1, 9);
        idle(4);
        n_cmp++;
        if (fifo_count_o !== CW'(4) || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL ovfpop_state: cnt=%0d ov=%b want 4 0", fifo_count_o, overflow_o);
        end
        n_cmp++;
        if (got_q.size() != base + 1 || got_q[got_q.size()-1] !== 8'h01) begin
            n_err++; $display("FAIL ovfpop_popped: n=%0d last=%h want 1 01",
                              got_q.size() - base, got_q[got_q.size()-1]);
        end
        base = got_q.size();
        byte_ready_i = 1'b1;
        idle(8);
        byte_ready_i = 1'b0;
        n_cmp++;
        if (got_q.size() - base != 4) begin
            n_err++; $display("FAIL ovfpop_drain_n: got %0d want 4", got_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (got_q[base+i] !== 8'(i + 2)) begin
                    n_err++; $display("FAIL ovfpop_data[%0d]: got %h want %h", i, got_q[base+i], 8'(i + 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(8'h11, 1'b1, -1);
        idle(4);
        n_cmp++;
        if (fifo_count_o !== CW'(1) || byte_valid_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre: cnt=%0d v=%b want 1 1", fifo_count_o, byte_valid_o);
        end
        drive_bit(1'b0);            // start of 0x99
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({byte_valid_o, byte_data_o, frame_err_o, overflow_o, fifo_count_o} !== '0) begin
            n_err++; $display("FAIL rstmid_outputs: v=%b d=%h fe=%b ov=%b cnt=%0d want all 0",
                              byte_valid_o, byte_data_o, frame_err_o, overflow_o, fifo_count_o);
        end
        rx_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2 * CLK_DIV);
        send_frame(8'h42, 1'b1, -1);
        idle(4);
        n_cmp++;
        if (fifo_count_o !== CW'(1) || byte_data_o !== 8'h42 || byte_valid_o !== 1'b1) begin
            n_err++; $display("FAIL rstmid_after: cnt=%0d d=%h v=%b want 1 42 1",
                              fifo_count_o, byte_data_o, byte_valid_o);
        end
    endtask

    // Random bytes, random stop-bit corruption and random consumer stalls.
    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe, base, fe0;
        do_reset();
        base = got_q.size(); fe0 = fe_cnt; exp_fe = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    logic [7:0] d;
                    logic       good;
                    d    = 8'($urandom);
                    good = ($urandom_range(0, 4) != 0);
                    send_frame(d, good, -1);
                    if (good) begin
                        exp_q.push_back(d);
                        idle($urandom_range(0, 3));
                    end else begin
                        exp_fe++;
                        idle(CLK_DIV + $urandom_range(0, CLK_DIV));
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    byte_ready_i = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                byte_ready_i = 1'b1;
            end
        join
        idle(8);
        byte_ready_i = 1'b0;
        n_cmp++;
        if (got_q.size() - base != exp_q.size()) begin
            n_err++; $display("FAIL rand_n: got %0d want %0d", got_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[base+i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, got_q[base+i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (fe_cnt - fe0 != exp_fe || overflow_o !== 1'b0) begin
            n_err++; $display("FAIL rand_flags: fe=%0d ov=%b want %0d 0", fe_cnt - fe0, overflow_o, exp_fe);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_overflow_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Synthesizable UART receiver that consumes the serial `uart_tx` output of `soc_top`.
- Decodes 8N1 frames into bytes and buffers them in a small FIFO with a valid/ready output.
- Sits directly downstream of the SoC UART pin, in the system bench and in FPGA console bridges.
- Reports framing errors and FIFO overflow so console-capture checkers can flag corrupted output.

Parameters:
- CLK_DIV, 868, clk cycles per bit period (100 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, 2..256.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_i  input  1  serial line from SoC uart_tx; idle high; asynchronous to clk
- byte_data_o  output  8  FIFO head byte; valid only when byte_valid_o=1
- byte_valid_o  output  1  FIFO non-empty
- byte_ready_i  input  1  consumer accepts head byte when byte_valid_o=1
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overflow_o  output  1  sticky: a byte was dropped because the FIFO was full
- fifo_count_o  output  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: all outputs 0; byte_data_o is 0. Synchronizer flops reset to 1 (idle line). State is IDLE, counters 0, FIFO empty.
- Synchronizer: rx_i passes through a 2-flop synchronizer to form rx_s. All decoding uses rx_s only.
- FSM states: IDLE, START, DATA, STOP, BRK.
- IDLE: when rx_s=0, load bit_cnt=CLK_DIV/2-1 and go to START.
- START: decrement bit_cnt. When bit_cnt=0, sample rx_s:
  - rx_s=1: glitch; return to IDLE with no outputs.
  - rx_s=0: load bit_cnt=CLK_DIV-1, bit_idx=0, go to DATA.
- DATA: at each bit_cnt=0, shift rx_s into the shift register LSB first and reload bit_cnt=CLK_DIV-1. After bit_idx=7 is sampled, go to STOP.
- STOP: at bit_cnt=0, sample rx_s:
  - rx_s=1: push the byte and go to IDLE in the same cycle. This allows a back-to-back start bit to be detected half a bit early.
  - rx_s=0: pulse frame_err_o for one cycle, discard the byte, go to BRK.
- BRK: wait for rx_s=1, then go to IDLE. A line held low (break) therefore produces exactly one frame_err pulse.
- Latency: the pushed byte appears on byte_valid_o/byte_data_o the cycle after the stop-bit sample.
- FIFO: first-word-fall-through.
  - Pop when byte_valid_o & byte_ready_i.
  - Push when a good stop bit is sampled and (not full, or a pop occurs in the same cycle).
  - Push with pop on an empty FIFO: the pop is impossible (valid=0), so only the push happens.
  - Push on full with no pop: byte dropped, overflow_o set to 1 and held until reset. FIFO contents and count are unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. fifo_count_o is the exact occupancy, 0..FIFO_DEPTH.
- Reset mid-frame: the frame is abandoned and the FIFO is cleared. After reset release, the receiver re-arms in IDLE only on the next falling edge of rx_s. A line already low at release is treated as a start edge.
- byte_ready_i is ignored when byte_valid_o=0.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP, BRK)
  - UART_DATA_BITS=8
  - default CLK_DIV constant
- Sub-module sync_fifo (params WIDTH, DEPTH; ports push/pop/din/dout/empty/full/count). It is reusable by the future uart_tx block.
- uart_rx_capture holds the synchronizer, FSM and bit counters, and instantiates sync_fifo.

Test Plan:
All scenarios use CLK_DIV=16 and FIFO_DEPTH=4.
- Single byte: drive 0xA5 8N1, byte_ready_i=1 → byte_valid_o for 1 cycle with byte_data_o=0xA5; frame_err_o and overflow_o stay 0.
- Back-to-back bytes 0x00, 0xFF, 0x55 with no idle gap, byte_ready_i=0 → fifo_count_o=3; draining yields 0x00, 0xFF, 0x55 in order.
- Start glitch: rx_i low for 4 cycles, then high → no byte, state returns to IDLE; a following 0x3C is received correctly.
- Framing error: byte 0x81 with stop bit low, then line high → one frame_err_o pulse, no byte pushed; next frame 0x7E is received.
- Overflow: 5 bytes 0x01..0x05 with byte_ready_i=0 → count=4, overflow_o=1, contents 0x01..0x04. Repeat with a pop timed in the same cycle as the 5th push → no overflow, FIFO holds 0x02..0x05.
- Reset asserted mid-DATA of byte 0x99 → outputs 0 immediately; after release, a clean 0x42 is received, count=1.
